// File: rtl/mips_dvc_bus_arb_if.sv
// Device-bus bundle seen by the two-master arbiter: core side, aux side,
// device side and the core pause line.
interface mips_dvc_bus_arb_if;
  logic        pause_i;
  logic        core_pause_o;

  logic [31:0] cpu_addr;
  logic [3:0]  cpu_mem_ctl;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;

  logic        aux_req;
  logic [31:0] aux_addr;
  logic [3:0]  aux_mem_ctl;
  logic [31:0] aux_din;
  logic        aux_gnt;
  logic        aux_ack;
  logic [31:0] aux_dout;

  logic [31:0] dvc_addr;
  logic [3:0]  dvc_mem_ctl;
  logic [31:0] dvc_din;
  logic [31:0] dvc_dout;

  // Arbiter side
  modport slave (
    input  pause_i,
    input  cpu_addr, cpu_mem_ctl, cpu_din,
    input  aux_req, aux_addr, aux_mem_ctl, aux_din,
    input  dvc_dout,
    output core_pause_o, cpu_dout,
    output aux_gnt, aux_ack, aux_dout,
    output dvc_addr, dvc_mem_ctl, dvc_din
  );

  // Environment side: core, aux master and device block
  modport master (
    output pause_i,
    output cpu_addr, cpu_mem_ctl, cpu_din,
    output aux_req, aux_addr, aux_mem_ctl, aux_din,
    output dvc_dout,
    input  core_pause_o, cpu_dout,
    input  aux_gnt, aux_ack, aux_dout,
    input  dvc_addr, dvc_mem_ctl, dvc_din
  );
endinterface

// File: rtl/mips_dvc_bus_arb.sv
// Two-master device-bus arbiter: the core owns the bus by default, an aux
// master borrows it for single accesses while the core is held in pause.
module mips_dvc_bus_arb #(
  parameter int unsigned DVC_LAT    = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic              clk,
  input logic              rst,
  mips_dvc_bus_arb_if.slave bus
);

  localparam logic [1:0] ST_CPU      = 2'd0;
  localparam logic [1:0] ST_AUX_ACC  = 2'd1;
  localparam logic [1:0] ST_AUX_WAIT = 2'd2;
  localparam logic [1:0] ST_AUX_DONE = 2'd3;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0] WAIT_INIT  = 2'(DVC_LAT - 1);
  localparam logic [3:0] CTL_NOP    = 4'h0;

  logic [1:0]  state, state_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic [1:0]  wait_cnt, wait_nxt;
  logic [31:0] aux_dout_q, aux_dout_nxt;
  logic        aux_gnt_q, aux_ack_q;
  logic        cpu_busy;
  logic        grant;

  assign cpu_busy = (bus.cpu_mem_ctl != CTL_NOP);
  assign grant    = bus.aux_req && (!cpu_busy || (starve_cnt == STARVE_LIM));

  always_comb begin
    state_nxt    = state;
    starve_nxt   = starve_cnt;
    wait_nxt     = wait_cnt;
    aux_dout_nxt = aux_dout_q;
    case (state)
      ST_CPU: begin
        if (!bus.aux_req)
          starve_nxt = '0;
        else if (cpu_busy && (starve_cnt != STARVE_LIM))
          starve_nxt = starve_cnt + 4'd1;
        if (grant)
          state_nxt = ST_AUX_ACC;
      end
      ST_AUX_ACC: begin
        wait_nxt  = WAIT_INIT;
        state_nxt = ST_AUX_WAIT;
      end
      ST_AUX_WAIT: begin
        // wait_cnt reaching zero marks the cycle in which dvc_dout is valid
        if (wait_cnt == '0) begin
          aux_dout_nxt = bus.dvc_dout;
          state_nxt    = ST_AUX_DONE;
        end else begin
          wait_nxt = wait_cnt - 2'd1;
        end
      end
      ST_AUX_DONE: begin
        starve_nxt = '0;
        state_nxt  = ST_CPU;
      end
      default: state_nxt = ST_CPU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_CPU;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      aux_dout_q <= '0;
      aux_gnt_q  <= 1'b0;
      aux_ack_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      wait_cnt   <= wait_nxt;
      aux_dout_q <= aux_dout_nxt;
      aux_gnt_q  <= (state_nxt != ST_CPU);
      aux_ack_q  <= (state_nxt == ST_AUX_DONE);
    end
  end

  // A core access overlapping AUX_ACC is simply frozen by the pause and
  // replayed by the core afterwards; nothing is buffered here.
  always_comb begin
    bus.dvc_addr    = bus.cpu_addr;
    bus.dvc_mem_ctl = bus.cpu_mem_ctl;
    bus.dvc_din     = bus.cpu_din;
    case (state)
      ST_AUX_ACC: begin
        bus.dvc_addr    = bus.aux_addr;
        bus.dvc_mem_ctl = bus.aux_mem_ctl;
        bus.dvc_din     = bus.aux_din;
      end
      ST_AUX_WAIT, ST_AUX_DONE: begin
        bus.dvc_addr    = bus.aux_addr;
        bus.dvc_mem_ctl = CTL_NOP;
        bus.dvc_din     = bus.aux_din;
      end
      default: ;
    endcase
  end

  assign bus.core_pause_o = bus.pause_i || (state != ST_CPU);
  assign bus.cpu_dout     = bus.dvc_dout;
  assign bus.aux_gnt      = aux_gnt_q;
  assign bus.aux_ack      = aux_ack_q;
  assign bus.aux_dout     = aux_dout_q;

endmodule
